// File: rtl/debug_mem_reader_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the debug memory dump reader.
package debug_mem_reader_pkg;

    localparam int unsigned PROC_BITS_DEF       = 32;
    localparam int unsigned DATA_ADDRS_BITS_DEF = 5;
    localparam int unsigned DUMP_WORDS_DEF      = 32;
    localparam int unsigned BYTE_BITS           = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT_TX,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_mem_reader_if.sv
// Control, data-memory and UART-transmitter signals of the debug memory dump reader.
interface debug_mem_reader_if
    import debug_mem_reader_pkg::*;
#(
    parameter int unsigned PROC_BITS       = PROC_BITS_DEF,
    parameter int unsigned DATA_ADDRS_BITS = DATA_ADDRS_BITS_DEF
);

    logic                       i_start;
    logic                       o_stall;
    logic                       o_debug_read_data;
    logic [DATA_ADDRS_BITS-1:0] o_debug_read_address;
    logic [PROC_BITS-1:0]       i_mem_data;
    logic [7:0]                 o_tx_data;
    logic                       o_tx_start;
    logic                       i_tx_done;
    logic                       o_busy;
    logic                       o_done;

    // The reader drives memory address and transmitter strobes.
    modport master (
        input  i_start, i_mem_data, i_tx_done,
        output o_stall, o_debug_read_data, o_debug_read_address,
               o_tx_data, o_tx_start, o_busy, o_done
    );

    // Requester, data memory and transmitter side.
    modport slave (
        output i_start, i_mem_data, i_tx_done,
        input  o_stall, o_debug_read_data, o_debug_read_address,
               o_tx_data, o_tx_start, o_busy, o_done
    );

endinterface

// File: rtl/debug_mem_reader.sv
// Dumps DUMP_WORDS data-memory words over a byte-wide UART transmitter, LSB first, stalling the pipeline meanwhile.
module debug_mem_reader
    import debug_mem_reader_pkg::*;
#(
    parameter int unsigned PROC_BITS       = PROC_BITS_DEF,
    parameter int unsigned DATA_ADDRS_BITS = DATA_ADDRS_BITS_DEF,
    parameter int unsigned DUMP_WORDS      = DUMP_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    debug_mem_reader_if.master bus
);

    localparam int unsigned BYTES     = PROC_BITS / BYTE_BITS;
    localparam int unsigned BIDX_BITS = idx_bits(BYTES);
    localparam logic [BIDX_BITS-1:0]       LAST_BYTE = BIDX_BITS'(BYTES - 1);
    localparam logic [DATA_ADDRS_BITS-1:0] LAST_WORD = DATA_ADDRS_BITS'(DUMP_WORDS - 1);

    state_t                     state_q;
    logic [DATA_ADDRS_BITS-1:0] word_q;
    logic [BIDX_BITS-1:0]       byte_q;
    logic [PROC_BITS-1:0]       shift_q;
    logic [PROC_BITS-1:0]       shift_nxt;
    logic                       stall_q;
    logic                       rd_q;
    logic [7:0]                 tx_data_q;
    logic                       tx_start_q;
    logic                       busy_q;
    logic                       done_q;

    assign shift_nxt = shift_q >> BYTE_BITS;

    // The word counter doubles as the presented address, so it holds naturally between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            stall_q    <= 1'b0;
            rd_q       <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        word_q  <= '0;
                        byte_q  <= '0;
                        stall_q <= 1'b1;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR:  state_q <= ST_WAIT;
                // Extra cycle covers the synchronous BRAM read latency.
                ST_WAIT:  state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    shift_q    <= bus.i_mem_data;
                    byte_q     <= '0;
                    rd_q       <= 1'b0;
                    tx_data_q  <= bus.i_mem_data[7:0];
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND:  state_q <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        shift_q <= shift_nxt;
                        byte_q  <= byte_q + BIDX_BITS'(1);
                        if (byte_q == LAST_BYTE) begin
                            state_q <= ST_NEXT;
                        end else begin
                            tx_data_q  <= shift_nxt[7:0];
                            tx_start_q <= 1'b1;
                            state_q    <= ST_SEND;
                        end
                    end
                end
                // Stop on the last word instead of incrementing, so a full-range dump never wraps.
                ST_NEXT: begin
                    if (word_q == LAST_WORD) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        word_q  <= word_q + DATA_ADDRS_BITS'(1);
                        rd_q    <= 1'b1;
                        state_q <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_stall              = stall_q;
    assign bus.o_debug_read_data    = rd_q;
    assign bus.o_debug_read_address = word_q;
    assign bus.o_tx_data            = tx_data_q;
    assign bus.o_tx_start           = tx_start_q;
    assign bus.o_busy               = busy_q;
    assign bus.o_done               = done_q;

endmodule

// File: tb/tb_debug_mem_reader.sv
// Directed bench: a two-word dump instance and a full-range eight-word instance with BRAM and UART models.
module tb_debug_mem_reader;

    localparam int unsigned PW  = 32;
    localparam int unsigned AWA = 5;
    localparam int unsigned AWB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    debug_mem_reader_if #(.PROC_BITS(PW), .DATA_ADDRS_BITS(AWA)) bus_a ();
    debug_mem_reader_if #(.PROC_BITS(PW), .DATA_ADDRS_BITS(AWB)) bus_b ();

    debug_mem_reader #(.PROC_BITS(PW), .DATA_ADDRS_BITS(AWA), .DUMP_WORDS(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master)
    );
    debug_mem_reader #(.PROC_BITS(PW), .DATA_ADDRS_BITS(AWB), .DUMP_WORDS(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories
    logic [PW-1:0] mem_a [0:(1<<AWA)-1];
    logic [PW-1:0] mem_b [0:(1<<AWB)-1];
    always @(posedge clk) bus_a.i_mem_data <= mem_a[bus_a.o_debug_read_address];
    always @(posedge clk) bus_b.i_mem_data <= mem_b[bus_b.o_debug_read_address];

    // Transmitter models: done strobe about 5 cycles after each start strobe, plus injectable spurious strobes
    logic [2:0] cnt_a = '0, cnt_b = '0;
    logic done_m_a = 1'b0, done_m_b = 1'b0;
    logic spur_a = 1'b0;
    assign bus_a.i_tx_done = done_m_a | spur_a;
    assign bus_b.i_tx_done = done_m_b;

    always @(posedge clk) begin
        done_m_a <= 1'b0;
        if (cnt_a != 0) begin
            cnt_a <= cnt_a - 3'd1;
            if (cnt_a == 3'd1) done_m_a <= 1'b1;
        end else if (bus_a.o_tx_start) begin
            cnt_a <= 3'd4;
        end
    end

    always @(posedge clk) begin
        done_m_b <= 1'b0;
        if (cnt_b != 0) begin
            cnt_b <= cnt_b - 3'd1;
            if (cnt_b == 3'd1) done_m_b <= 1'b1;
        end else if (bus_b.o_tx_start) begin
            cnt_b <= 3'd4;
        end
    end

    // Monitors, sampled on the falling edge
    logic [7:0] bytes_a [$];
    logic [7:0] bytes_b [$];
    int addrs_a [$];
    int addrs_b [$];
    int done_cnt_a = 0, done_cnt_b = 0, txd_cnt_a = 0;
    int step_a = -1, first_rd_cyc_a = -1, first_tx_cyc_a = -1;
    logic rd_prev_a = 1'b0, rd_prev_b = 1'b0;

    always @(negedge clk) begin
        if (bus_a.o_tx_start) begin
            bytes_a.push_back(bus_a.o_tx_data);
            if (bytes_a.size() == 1) first_tx_cyc_a = cyc;
        end
        if (bus_a.o_done) done_cnt_a++;
        if (bus_a.i_tx_done) txd_cnt_a++;
        if (bus_a.o_debug_read_data && !rd_prev_a) begin
            addrs_a.push_back(int'(bus_a.o_debug_read_address));
            if (addrs_a.size() == 1) first_rd_cyc_a = cyc;
            if (bus_a.o_debug_read_address == AWA'(1) && step_a < 0) step_a = txd_cnt_a;
        end
        rd_prev_a = bus_a.o_debug_read_data;
    end

    always @(negedge clk) begin
        if (bus_b.o_tx_start) bytes_b.push_back(bus_b.o_tx_data);
        if (bus_b.o_done) done_cnt_b++;
        if (bus_b.o_debug_read_data && !rd_prev_b)
            addrs_b.push_back(int'(bus_b.o_debug_read_address));
        rd_prev_b = bus_b.o_debug_read_data;
    end

    task automatic clear_mon;
        bytes_a.delete(); bytes_b.delete(); addrs_a.delete(); addrs_b.delete();
        done_cnt_a = 0; done_cnt_b = 0; txd_cnt_a = 0;
        step_a = -1; first_rd_cyc_a = -1; first_tx_cyc_a = -1;
    endtask

    task automatic pulse_start_a;
        @(posedge clk); #1 bus_a.i_start = 1'b1;
        @(posedge clk); #1 bus_a.i_start = 1'b0;
    endtask

    task automatic pulse_start_b;
        @(posedge clk); #1 bus_b.i_start = 1'b1;
        @(posedge clk); #1 bus_b.i_start = 1'b0;
    endtask

    task automatic wait_done_a(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_cnt_a > 0) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic wait_done_b(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_cnt_b > 0) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic check_word_bytes_a(input string tag);
        logic [7:0] exp_a [8];
        exp_a = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        total++;
        if (bytes_a.size() != 8) begin
            bad++; $display("FAIL %s_count got=%0d want=8", tag, bytes_a.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (bytes_a[i] !== exp_a[i]) begin
                    bad++; $display("FAIL %s_byte%0d got=%02h want=%02h", tag, i, bytes_a[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [44:0] outs_a;
        logic [42:0] outs_b;
        repeat (3) @(posedge clk);
        #1;
        outs_a = {bus_a.o_stall, bus_a.o_debug_read_data, bus_a.o_debug_read_address,
                  bus_a.o_tx_data, bus_a.o_tx_start, bus_a.o_busy, bus_a.o_done, 27'd0};
        outs_b = {bus_b.o_stall, bus_b.o_debug_read_data, bus_b.o_debug_read_address,
                  bus_b.o_tx_data, bus_b.o_tx_start, bus_b.o_busy, bus_b.o_done, 27'd0};
        total++;
        if (outs_a !== '0) begin bad++; $display("FAIL reset_outs_a got=%0h want=0", outs_a); end
        total++;
        if (outs_b !== '0) begin bad++; $display("FAIL reset_outs_b got=%0h want=0", outs_b); end
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_dump;
        bit ok;
        clear_mon();
        pulse_start_a();
        @(posedge clk); #1;
        total++;
        if (bus_a.o_stall !== 1'b1 || bus_a.o_busy !== 1'b1) begin
            bad++; $display("FAIL dump_stall_busy got=%b%b want=11", bus_a.o_stall, bus_a.o_busy);
        end
        wait_done_a(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL dump_timeout got=0 want=1"); end
        total++;
        if (bus_a.o_stall !== 1'b0 || bus_a.o_busy !== 1'b0) begin
            bad++; $display("FAIL dump_stall_after_done got=%b%b want=00", bus_a.o_stall, bus_a.o_busy);
        end
        repeat (10) @(posedge clk);
        check_word_bytes_a("dump");
        total++;
        if (done_cnt_a != 1) begin bad++; $display("FAIL dump_done_pulses got=%0d want=1", done_cnt_a); end
    endtask

    task automatic test_addr_timing;
        total++;
        if (addrs_a.size() != 2) begin
            bad++; $display("FAIL addr_visits got=%0d want=2", addrs_a.size());
        end else begin
            total++;
            if (addrs_a[0] != 0 || addrs_a[1] != 1) begin
                bad++; $display("FAIL addr_order got=%0d,%0d want=0,1", addrs_a[0], addrs_a[1]);
            end
        end
        // ADDR, WAIT, CAPTURE, then the first SEND cycle
        total++;
        if (first_tx_cyc_a - first_rd_cyc_a != 3) begin
            bad++; $display("FAIL addr_to_send got=%0d want=3", first_tx_cyc_a - first_rd_cyc_a);
        end
        total++;
        if (step_a != 4) begin bad++; $display("FAIL addr_step_after_txdone got=%0d want=4", step_a); end
    endtask

    task automatic test_repeat_start;
        bit ok;
        clear_mon();
        pulse_start_a();
        for (int i = 0; i < 6; i++) begin
            repeat (5) @(posedge clk);
            pulse_start_a();
        end
        wait_done_a(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL repeat_timeout got=0 want=1"); end
        repeat (20) @(posedge clk);
        check_word_bytes_a("repeat");
        total++;
        if (done_cnt_a != 1) begin bad++; $display("FAIL repeat_done_pulses got=%0d want=1", done_cnt_a); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [44:0] outs;
        clear_mon();
        pulse_start_a();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (bytes_a.size() == 2) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rstmid_wait got=%0d want=2", bytes_a.size()); end
        #2 rst = 1'b0;
        #1;
        outs = {bus_a.o_stall, bus_a.o_debug_read_data, bus_a.o_debug_read_address,
                bus_a.o_tx_data, bus_a.o_tx_start, bus_a.o_busy, bus_a.o_done, 27'd0};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL rstmid_outs got=%0h want=0", outs); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        clear_mon();
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (bytes_a.size() != 0 || bus_a.o_busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_resume got=%0d/%b want=0/0", bytes_a.size(), bus_a.o_busy);
        end
        pulse_start_a();
        wait_done_a(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rstmid_restart_timeout got=0 want=1"); end
        repeat (10) @(posedge clk);
        total++;
        if (addrs_a.size() == 0 || addrs_a[0] != 0) begin
            bad++; $display("FAIL rstmid_restart_addr got=%0d want=0", (addrs_a.size() == 0) ? -1 : addrs_a[0]);
        end
        check_word_bytes_a("rstmid");
    endtask

    task automatic test_spurious;
        bit ok;
        int hits;
        clear_mon();
        @(posedge clk); #1 spur_a = 1'b1;
        @(posedge clk); #1 spur_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus_a.o_busy !== 1'b0 || bus_a.o_stall !== 1'b0 || bytes_a.size() != 0) begin
            bad++; $display("FAIL spur_idle got=%b%b/%0d want=00/0", bus_a.o_busy, bus_a.o_stall, bytes_a.size());
        end
        pulse_start_a();
        hits = 0;
        // Strobe i_tx_done on the edge that leaves SEND for the first three bytes
        for (int i = 0; i < 300 && hits < 3; i++) begin
            @(negedge clk);
            if (bus_a.o_tx_start) begin
                spur_a = 1'b1;
                @(posedge clk); #1 spur_a = 1'b0;
                hits++;
            end
        end
        wait_done_a(400, ok);
        total++;
        if (!ok || hits != 3) begin bad++; $display("FAIL spur_send_run got=%0d/%0d want=1/3", ok, hits); end
        repeat (10) @(posedge clk);
        check_word_bytes_a("spur");
        total++;
        if (done_cnt_a != 1) begin bad++; $display("FAIL spur_done_pulses got=%0d want=1", done_cnt_a); end
    endtask

    task automatic test_full_range;
        bit ok;
        clear_mon();
        pulse_start_b();
        wait_done_b(2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_timeout got=0 want=1"); end
        repeat (10) @(posedge clk);
        total++;
        if (addrs_b.size() != 8) begin
            bad++; $display("FAIL full_addr_count got=%0d want=8", addrs_b.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (addrs_b[i] != i) begin bad++; $display("FAIL full_addr%0d got=%0d want=%0d", i, addrs_b[i], i); end
            end
        end
        total++;
        if (bytes_b.size() != 32) begin
            bad++; $display("FAIL full_byte_count got=%0d want=32", bytes_b.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                total++;
                if (bytes_b[i] !== 8'(i)) begin bad++; $display("FAIL full_byte%0d got=%02h want=%02h", i, bytes_b[i], 8'(i)); end
            end
        end
        total++;
        if (done_cnt_b != 1 || bus_b.o_busy !== 1'b0) begin
            bad++; $display("FAIL full_done got=%0d/%b want=1/0", done_cnt_b, bus_b.o_busy);
        end
    endtask

    initial begin
        bus_a.i_start = 1'b0;
        bus_b.i_start = 1'b0;
        for (int i = 0; i < (1 << AWA); i++) mem_a[i] = '0;
        mem_a[0] = 32'h1122_3344;
        mem_a[1] = 32'hAABB_CCDD;
        for (int w = 0; w < (1 << AWB); w++)
            mem_b[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};

        test_reset();
        test_dump();
        test_addr_timing();
        test_repeat_start();
        test_reset_mid();
        test_spurious();
        test_full_range();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_mem_reader.md
DEBUG_MEM_READER -- requirements
Module: debug_mem_reader

Interface
REQ-001 Parameter PROC_BITS, default `PROC_BITS (32); width of a data-memory word.
REQ-002 Parameter DATA_ADDRS_BITS, default `DATA_ADDRS_BITS; width of the data-memory address.
REQ-003 Parameter DUMP_WORDS, default 32; number of words dumped per request, range 1..2**DATA_ADDRS_BITS.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  one-cycle dump request.
REQ-007 o_stall  output  1  high while dumping; drives the memory stage enable low and gates the pipeline.
REQ-008 o_debug_read_data  output  1  high while a debug read address is presented.
REQ-009 o_debug_read_address  output  DATA_ADDRS_BITS  word address presented to data memory.
REQ-010 i_mem_data  input  PROC_BITS  memory read data (load filter forced to full word); valid one cycle after the address.
REQ-011 o_tx_data  output  8  byte to the UART transmitter.
REQ-012 o_tx_start  output  1  one-cycle strobe: o_tx_data valid, begin transmission.
REQ-013 i_tx_done  input  1  one-cycle strobe from the transmitter: byte finished.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_done  output  1  one-cycle pulse after the last byte of the last word completes.

Function
REQ-016 FSM states: IDLE, ADDR, WAIT, CAPTURE, SEND, WAIT_TX, NEXT, DONE.
REQ-017 IDLE: i_start=1 -> clear address counter and byte index, go to ADDR. i_start is ignored in every other state.
REQ-018 ADDR: drive o_debug_read_address = word counter, assert o_debug_read_data, go to WAIT.
REQ-019 WAIT: hold the address for one cycle to cover the synchronous BRAM read latency, go to CAPTURE.
REQ-020 CAPTURE: latch i_mem_data into a PROC_BITS shift register, set byte index to 0, go to SEND.
REQ-021 SEND: pulse o_tx_start for exactly one cycle with o_tx_data = shift[7:0], go to WAIT_TX.
REQ-022 Bytes are sent least-significant first; PROC_BITS/8 bytes are sent per word.
REQ-023 WAIT_TX: on i_tx_done, shift the register right by 8 and increment the byte index.
  - If more bytes remain in the word, go to SEND.
  - Otherwise go to NEXT.
REQ-024 An i_tx_done in any state other than WAIT_TX is ignored.
REQ-025 NEXT: if word counter = DUMP_WORDS-1, go to DONE; otherwise increment the counter and go to ADDR.
REQ-026 The word counter never wraps during a dump. With DUMP_WORDS = 2**DATA_ADDRS_BITS, the last address is all ones and the counter is not incremented past it.
REQ-027 DONE: assert o_done for one cycle, go to IDLE.
REQ-028 o_stall is asserted from the cycle after i_start is accepted through the DONE cycle inclusive.
REQ-029 o_debug_read_data is high only in ADDR, WAIT and CAPTURE.
REQ-030 o_debug_read_address holds its value outside ADDR, WAIT and CAPTURE.
REQ-031 All outputs are registered; none is combinational from an input.
REQ-032 Transmitter timing is not bounded; the FSM waits in WAIT_TX indefinitely.

Reset
REQ-033 rst=0 at any time, including mid-dump, forces IDLE immediately.
REQ-034 While rst=0, every output is 0: o_stall, o_debug_read_data, o_debug_read_address, o_tx_data, o_tx_start, o_busy and o_done.
REQ-035 While rst=0, the word counter, byte index and shift register are cleared.
REQ-036 After reset release, a new i_start is required to begin a dump; an interrupted dump is not resumed.

Structure
REQ-037 PROC_BITS, DATA_ADDRS_BITS and the FSM state encodings belong in constants.vh; the module defines no private copies.
REQ-038 The design is a single flat module with no sub-module; the UART transmitter is external.

Verification
REQ-039 Memory with word0=0x11223344 and word1=0xAABBCCDD; DUMP_WORDS=2; i_start pulse; transmitter model returns i_tx_done 5 cycles after each o_tx_start.
  - Required: o_tx_data sequence 44,33,22,11,DD,CC,BB,AA.
  - Required: exactly 8 o_tx_start pulses, then one o_done pulse, and o_stall low the cycle after o_done.
REQ-040 Address-timing check.
  - Required: o_debug_read_address=0 exactly two cycles before CAPTURE latches 0x11223344.
  - Required: the address steps to 1 only after the 4th i_tx_done.
REQ-041 Repeat i_start pulses while o_busy=1.
  - Required: ignored; byte count stays 4*DUMP_WORDS; o_done pulses once.
REQ-042 Drive rst low after the 2nd byte of word 0.
  - Required: all outputs 0 within the same cycle.
  - Required: no further o_tx_start; a new i_start restarts from address 0 with byte 0x44.
REQ-043 DATA_ADDRS_BITS=3, DUMP_WORDS=8.
  - Required: addresses 0..7 in order, no revisit of address 0, o_done after 32 bytes.
REQ-044 Spurious i_tx_done in IDLE and in SEND.
  - Required: no state change and no byte skipped.
